// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron datapath and its synaptic input stage.
// Build option: SYN_INHIBIT_EN selects signed (inhibitory-capable) weights.
package lif_pkg;

    localparam int CUR_W   = 8;
    localparam int CUR_MAX = 255;
    localparam int W_W     = 8;

`ifdef SYN_INHIBIT_EN
    typedef logic signed [W_W-1:0] weight_t;
`else
    typedef logic [W_W-1:0] weight_t;
`endif

    // Clamp a signed intermediate result into the 0..CUR_MAX current range.
    function automatic logic [CUR_W-1:0] sat_cur(input logic signed [31:0] x);
        if (x < 0)
            return '0;
        else if (x > CUR_MAX)
            return CUR_W'(CUR_MAX);
        else
            return CUR_W'(x);
    endfunction

endpackage

// File: rtl/synapse_weight_bank.sv
// Per-synapse weight register file with range-checked writes and a one-cycle write acknowledge.
// Build option: SYN_INHIBIT_EN (weights interpreted as signed via weight_t).
module synapse_weight_bank
    import lif_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(N_IN)-1:0] wr_addr,
    input  logic [W_W-1:0]          wr_data,
    output logic                    wr_ack,
    output weight_t                 weights [N_IN]
);

    localparam int AW = $clog2(N_IN);

    logic wr_ok;

    // Addresses past the last synapse only exist when N_IN is not a power of two.
    assign wr_ok = wr_en && (32'(wr_addr) < N_IN);

    // NOTE: the weight file is a handful of flops, not a RAM, so it is cleared on reset
    // like any other state; all sequential updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++)
                weights[i] <= '0;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_ok;
            for (int i = 0; i < N_IN; i++)
                if (wr_ok && wr_addr == AW'(i))
                    weights[i] <= weight_t'(wr_data);
        end
    end

endmodule

// File: rtl/synapse_current.sv
// Synaptic input stage: spike register, weighted adder tree and leaky saturating trace.
// Build option: SYN_INHIBIT_EN enables signed weights and a clamp at zero.
module synapse_current
    import lif_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    wr_en,
    input  logic [$clog2(N_IN)-1:0] wr_addr,
    input  logic [W_W-1:0]          wr_data,
    output logic                    wr_ack,
    output logic [CUR_W-1:0]        current,
    output logic                    active
);

    localparam int SUM_W = W_W + $clog2(N_IN);
    localparam int LW    = CUR_W + 1;

    weight_t           weights [N_IN];
    logic [N_IN-1:0]   spike_q;
    logic [CUR_W-1:0]  syn;
    logic [CUR_W-1:0]  syn_next;
    logic [LW-1:0]     leak_num;
    logic [CUR_W-1:0]  leak;
    logic signed [31:0] nxt;
`ifdef SYN_INHIBIT_EN
    logic signed [SUM_W-1:0] sum;
`else
    logic [SUM_W-1:0] sum;
`endif

    synapse_weight_bank #(
        .N_IN(N_IN)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack (wr_ack),
        .weights(weights)
    );

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            if (spike_q[i])
                sum = sum + SUM_W'(weights[i]);
    end

    // Ceiling shift: any non-zero trace leaks at least 1, so it always reaches 0.
    assign leak_num = {1'b0, syn} + LW'((1 << DECAY_SHIFT) - 1);
    assign leak     = CUR_W'(leak_num >> DECAY_SHIFT);
    assign nxt      = 32'(syn) - 32'(leak) + 32'(sum);
    assign syn_next = sat_cur(nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q <= '0;
            syn     <= '0;
        end else begin
            spike_q <= spike_in;
            syn     <= syn_next;
        end
    end

    assign current = syn;
    assign active  = |syn;

endmodule

// File: tb/tb_synapse_current.sv
// Self-checking bench for synapse_current: vector table with a latency-aligned scoreboard plus corner sequences.
module tb_synapse_current;

    typedef struct {
        logic [3:0] spike;
        logic [7:0] cur;
        logic       act;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] spike;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       a_ack, a_act, c_ack, c_act;
    logic [7:0] a_cur, c_cur;

    logic [4:0] b_spike;
    logic       b_wr_en;
    logic [2:0] b_wr_addr;
    logic [7:0] b_wr_data;
    logic       b_ack, b_act;
    logic [7:0] b_cur;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [12];
    vec_t sb [$];

    synapse_current #(.N_IN(4), .DECAY_SHIFT(1)) dut_a (
        .clk(clk), .rst(rst), .spike_in(spike), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(a_ack), .current(a_cur), .active(a_act)
    );

    synapse_current #(.N_IN(5), .DECAY_SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .spike_in(b_spike), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_ack(b_ack), .current(b_cur), .active(b_act)
    );

    synapse_current #(.N_IN(4), .DECAY_SHIFT(0)) dut_c (
        .clk(clk), .rst(rst), .spike_in(spike), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(c_ack), .current(c_cur), .active(c_act)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [1:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        check("wr_ack", a_ack, 1);
        wr_en = 1'b0;
    endtask

    // Output after edge j reflects the vector sampled at edge j-1.
    task automatic run_vectors(input int first, input int n);
        vec_t e;
        for (int j = first; j < first + n; j++) begin
            spike = tbl[j].spike;
            sb.push_back(tbl[j]);
            tick();
            if (j > first) begin
                e = sb.pop_front();
                check("vec_current", a_cur, e.cur);
                check("vec_active", a_act, e.act);
            end
        end
        spike = '0;
        tick();
        e = sb.pop_front();
        check("vec_current", a_cur, e.cur);
        check("vec_active", a_act, e.act);
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 8'd10,  1'b1};
        tbl[1]  = '{4'b0000, 8'd5,   1'b1};
        tbl[2]  = '{4'b0000, 8'd2,   1'b1};
        tbl[3]  = '{4'b0000, 8'd1,   1'b1};
        tbl[4]  = '{4'b0000, 8'd0,   1'b0};
        tbl[5]  = '{4'b0000, 8'd0,   1'b0};
        tbl[6]  = '{4'b1111, 8'd255, 1'b1};
        tbl[7]  = '{4'b0000, 8'd127, 1'b1};
        tbl[8]  = '{4'b0000, 8'd63,  1'b1};
        tbl[9]  = '{4'b0001, 8'd50,  1'b1};
`ifdef SYN_INHIBIT_EN
        tbl[10] = '{4'b0010, 8'd0,   1'b0};
        tbl[11] = '{4'b0000, 8'd0,   1'b0};
`else
        tbl[10] = '{4'b0010, 8'd201, 1'b1};
        tbl[11] = '{4'b0000, 8'd100, 1'b1};
`endif

        // Reset with a write presented: the write must be dropped.
        rst = 1'b1; spike = '0; wr_en = 1'b1; wr_addr = '0; wr_data = 8'd33;
        b_spike = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        tick();
        tick();
        check("rst_current", a_cur, 0);
        check("rst_active", a_act, 0);
        check("rst_wr_ack", a_ack, 0);
        rst = 1'b0; wr_en = 1'b0; spike = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_current", a_cur, 0);
            check("idle_active", a_act, 0);
            check("idle_wr_ack", a_ack, 0);
        end
        spike = '0;
        tick();

        // Single pulse decay.
        write_w(2'd0, 8'd10);
        run_vectors(0, 6);

        // Saturation from a raw 261.
        write_w(2'd0, 8'd100);
        write_w(2'd1, 8'd100);
        write_w(2'd2, 8'd60);
        write_w(2'd3, 8'd1);
        run_vectors(6, 3);
        for (int i = 0; i < 10; i++) tick();
        check("decayed", a_cur, 0);

        // Write and spike in the same cycle.
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd7; spike = 4'b0100;
        tick();
        wr_en = 1'b0; spike = '0;
        check("same_cyc_ack", a_ack, 1);
        check("same_cyc_cur0", a_cur, 0);
        tick();
        check("same_cyc_cur1", a_cur, 7);
        check("ack_pulse", a_ack, 0);
        for (int i = 0; i < 10; i++) tick();

        // Inhibitory weight (unsigned build sees 176).
        write_w(2'd0, 8'd50);
        write_w(2'd1, 8'hB0);
        run_vectors(9, 3);

        // Out-of-range addresses on a 5-input instance.
        b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_data = 8'd99;
        tick();
        check("oor5_ack", b_ack, 0);
        b_wr_addr = 3'd7;
        tick();
        check("oor7_ack", b_ack, 0);
        b_wr_addr = 3'd4; b_wr_data = 8'd9;
        tick();
        check("b_w4_ack", b_ack, 1);
        b_wr_en = 1'b0; b_spike = 5'b11111;
        tick();
        b_spike = '0;
        tick();
        check("b_current", b_cur, 9);

        // No-memory trace held steady, then reset mid-stream with a write presented.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_w(2'd0, 8'd3);
        write_w(2'd1, 8'd4);
        spike = 4'b0011;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("steady_cur", c_cur, 7);
            tick();
        end
        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd50;
        tick();
        check("mid_rst_cur", c_cur, 0);
        check("mid_rst_act", c_act, 0);
        check("mid_rst_ack", c_ack, 0);
        rst = 1'b0; wr_en = 1'b0; spike = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_cur", c_cur, 0);
        end
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
